// File: rtl/julia_pkg.sv
// Shared definitions for the Julia-set iteration engine: default fixed-point
// format, escape threshold, FSM state encoding and the saturation helper.
package julia_pkg;

  localparam int W_DEF    = 18;
  localparam int FRAC_DEF = 13;

  // Radius-squared threshold 4.0 expressed in the 2*frac format of a product.
  function automatic logic [63:0] escape_sq(input int frac);
    return 64'd4 << (2 * frac);
  endfunction

  localparam logic [63:0] ESCAPE_SQ = escape_sq(FRAC_DEF);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  // Clamp a wide signed value into the range of a w-bit two's-complement word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/julia_iter_if.sv
// Pixel input and result output channels of the Julia iteration engine.
interface julia_iter_if #(
  parameter int W     = 18,
  parameter int TAG_W = 20
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  z0_re;
  logic signed [W-1:0]  z0_im;
  logic signed [W-1:0]  c_re;
  logic signed [W-1:0]  c_im;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           iter;
  logic [TAG_W-1:0]     out_tag;

  // Pixel source / result sink side.
  modport master (
    output in_valid, z0_re, z0_im, c_re, c_im, in_tag, out_ready,
    input  in_ready, out_valid, iter, out_tag
  );

  // Engine side.
  modport slave (
    input  in_valid, z0_re, z0_im, c_re, c_im, in_tag, out_ready,
    output in_ready, out_valid, iter, out_tag
  );
endinterface

// File: rtl/julia_step.sv
// One combinational Julia step: escape test on the current z, and z^2 + c.
module julia_step
  import julia_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [W-1:0] i_zr,
  input  logic signed [W-1:0] i_zi,
  input  logic signed [W-1:0] i_cr,
  input  logic signed [W-1:0] i_ci,
  output logic signed [W-1:0] o_zr,
  output logic signed [W-1:0] o_zi,
  output logic                o_escape
);
  localparam logic [2*W:0] LP_ESC_SQ = (2*W+1)'(escape_sq(FRAC));

  logic signed [2*W-1:0] w_zr2;
  logic signed [2*W-1:0] w_zi2;
  logic signed [2*W-1:0] w_zri;
  logic signed [2*W:0]   w_diff;
  logic [2*W:0]          w_mag;
  logic signed [63:0]    w_re_sum;
  logic signed [63:0]    w_im_sum;

  // Full-precision products; no rounding before the escape test.
  assign w_zr2 = i_zr * i_zr;
  assign w_zi2 = i_zi * i_zi;
  assign w_zri = i_zr * i_zi;

  // Both squares are non-negative, so an unsigned 2W+1-bit sum cannot overflow.
  assign w_mag    = {1'b0, w_zr2} + {1'b0, w_zi2};
  assign o_escape = w_mag > LP_ESC_SQ;

  // Arithmetic shifts floor toward -inf; shifting zr*zi by FRAC-1 doubles it.
  assign w_diff   = (2*W+1)'(w_zr2) - (2*W+1)'(w_zi2);
  assign w_re_sum = 64'(w_diff >>> FRAC) + 64'(i_cr);
  assign w_im_sum = 64'(w_zri >>> (FRAC - 1)) + 64'(i_ci);

  assign o_zr = W'(sat(w_re_sum, W));
  assign o_zi = W'(sat(w_im_sum, W));
endmodule

// File: rtl/julia_iter.sv
// Per-pixel Julia iteration engine: accept z0/c/tag, iterate one step per
// clock until escape or the cap, then present the count with the tag.
module julia_iter
  import julia_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int MAX_ITER = 12,
  parameter int TAG_W    = 20
) (
  input logic         clk,
  input logic         rst_n,
  julia_iter_if.slave bus
);
  state_t              r_state;
  logic signed [W-1:0] r_zr;
  logic signed [W-1:0] r_zi;
  logic signed [W-1:0] r_cr;
  logic signed [W-1:0] r_ci;
  logic [7:0]          r_count;
  logic [TAG_W-1:0]    r_tag;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [7:0]          r_iter;
  logic [TAG_W-1:0]    r_out_tag;

  logic signed [W-1:0] w_zr_nxt;
  logic signed [W-1:0] w_zi_nxt;
  logic                w_escape;

  julia_step #(
    .W    (W),
    .FRAC (FRAC)
  ) u_step (
    .i_zr     (r_zr),
    .i_zi     (r_zi),
    .i_cr     (r_cr),
    .i_ci     (r_ci),
    .o_zr     (w_zr_nxt),
    .o_zi     (w_zi_nxt),
    .o_escape (w_escape)
  );

  // Handshake FSM with the iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here, datapath included, is cleared so that a
      // pixel interrupted by reset leaves no stale z, c, count or tag behind.
      r_state     <= IDLE;
      r_zr        <= '0;
      r_zi        <= '0;
      r_cr        <= '0;
      r_ci        <= '0;
      r_count     <= '0;
      r_tag       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_iter      <= '0;
      r_out_tag   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register in this block sees
      // the pre-edge values of the others, whatever the statement order.
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_zr       <= bus.z0_re;
            r_zi       <= bus.z0_im;
            r_cr       <= bus.c_re;
            r_ci       <= bus.c_im;
            r_tag      <= bus.in_tag;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ITER;
          end
        end
        ITER: begin
          if (w_escape || (r_count == 8'(MAX_ITER))) begin
            r_out_valid <= 1'b1;
            r_iter      <= r_count;
            r_out_tag   <= r_tag;
            r_state     <= DONE;
          end else begin
            r_zr    <= w_zr_nxt;
            r_zi    <= w_zi_nxt;
            r_count <= r_count + 8'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.iter      = r_iter;
  assign bus.out_tag   = r_out_tag;
endmodule
